// File: rtl/fetch_stall_resp.sv
// Fetch-side stall/flush responder: owns PC, IF/ID and the ID/EX bubble; optional FETCH_STALL_PERF_EN stall counter.
// Latency: registers update on each rising edge; idex_bubble is combinational from PCStall/branch_taken/state.
// Backpressure: PCStall holds PC and IF/ID in place; branch_taken overrides the stall and flushes IF/ID.
module fetch_stall_resp #(
  parameter int                 PC_W      = 16,
  parameter int                 INSTR_W   = 16,
  parameter logic [PC_W-1:0]    RESET_PC  = '0,
  parameter logic [PC_W-1:0]    PC_INC    = PC_W'(1),
  parameter logic [INSTR_W-1:0] NOP_INSTR = '0,
  parameter int                 MAX_STALL = 8
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               PCStall,
  input  logic               branch_taken,
  input  logic [PC_W-1:0]    branch_target,
  input  logic [INSTR_W-1:0] imem_instr,
  output logic [PC_W-1:0]    pc,
  output logic [INSTR_W-1:0] ifid_instr,
  output logic               ifid_valid,
  output logic               idex_bubble,
  output logic               stall_timeout,
  output logic [15:0]        stall_cycles
);

  localparam logic [1:0] RUN   = 2'd0;
  localparam logic [1:0] STALL = 2'd1;
  localparam logic [1:0] FLUSH = 2'd2;

  localparam int              SL_W   = $clog2(MAX_STALL + 1);
  localparam logic [SL_W-1:0] MAX_SL = SL_W'(MAX_STALL);

  logic [1:0]      state;
  logic [SL_W-1:0] stall_len;
  logic [SL_W-1:0] stall_len_inc;
  logic            hold;

  // A branch in the same cycle wins over the stall request.
  assign hold          = PCStall & ~branch_taken;
  assign stall_len_inc = (stall_len == MAX_SL) ? stall_len : stall_len + 1'b1;
  assign idex_bubble   = reset & (hold | (state == FLUSH));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pc            <= RESET_PC;
      ifid_instr    <= NOP_INSTR;
      ifid_valid    <= 1'b0;
      state         <= RUN;
      stall_len     <= '0;
      stall_timeout <= 1'b0;
    end else if (branch_taken) begin
      pc         <= branch_target;
      ifid_instr <= NOP_INSTR;
      ifid_valid <= 1'b0;
      state      <= FLUSH;
      stall_len  <= '0;
    end else if (PCStall) begin
      state     <= STALL;
      stall_len <= stall_len_inc;
      if (stall_len_inc == MAX_SL) begin
        stall_timeout <= 1'b1;
      end
    end else begin
      pc         <= pc + PC_INC;
      ifid_instr <= imem_instr;
      ifid_valid <= 1'b1;
      state      <= RUN;
      stall_len  <= '0;
    end
  end

`ifdef FETCH_STALL_PERF_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stall_cycles <= 16'h0000;
    end else if (hold && (stall_cycles != 16'hFFFF)) begin
      stall_cycles <= stall_cycles + 16'h0001;
    end
  end
`else
  assign stall_cycles = 16'h0000;
`endif

endmodule

// File: tb/tb_fetch_stall_resp.sv
// Randomized bench for fetch_stall_resp against a cycle-level reference model, plus directed literal checks.
module tb_fetch_stall_resp;
  localparam int MAXS = 8;

  logic        clock = 1'b0;
  logic        reset;
  logic        PCStall;
  logic        branch_taken;
  logic [15:0] branch_target;
  logic [15:0] imem_instr;
  logic [15:0] pc;
  logic [15:0] ifid_instr;
  logic        ifid_valid;
  logic        idex_bubble;
  logic        stall_timeout;
  logic [15:0] stall_cycles;

  int total = 0;
  int bad   = 0;
  bit cmp_on = 1'b0;

  // Reference model state
  logic [15:0] m_pc;
  logic [15:0] m_instr;
  logic        m_valid;
  bit          m_flushing;
  int          m_run;
  logic        m_timeout;
  int          m_cycles;

  fetch_stall_resp dut (
    .clock(clock), .reset(reset), .PCStall(PCStall), .branch_taken(branch_taken),
    .branch_target(branch_target), .imem_instr(imem_instr), .pc(pc),
    .ifid_instr(ifid_instr), .ifid_valid(ifid_valid), .idex_bubble(idex_bubble),
    .stall_timeout(stall_timeout), .stall_cycles(stall_cycles)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc = 16'h0000; m_instr = 16'h0000; m_valid = 1'b0;
    m_flushing = 1'b0; m_run = 0; m_timeout = 1'b0; m_cycles = 0;
  endtask

  function automatic logic m_bubble();
    if (!reset) return 1'b0;
    return (PCStall && !branch_taken) || m_flushing;
  endfunction

  function automatic logic [15:0] m_perf();
`ifdef FETCH_STALL_PERF_EN
    return 16'(m_cycles);
`else
    return 16'h0000;
`endif
  endfunction

  task automatic model_edge();
    if (branch_taken) begin
      m_pc = branch_target; m_instr = 16'h0000; m_valid = 1'b0;
      m_flushing = 1'b1; m_run = 0;
    end else if (PCStall) begin
      m_flushing = 1'b0;
      if (m_run < MAXS) m_run++;
      if (m_run >= MAXS) m_timeout = 1'b1;
      if (m_cycles < 65535) m_cycles++;
    end else begin
      m_pc = m_pc + 16'd1; m_instr = imem_instr; m_valid = 1'b1;
      m_flushing = 1'b0; m_run = 0;
    end
  endtask

  task automatic tick();
    @(posedge clock);
    if (reset) model_edge();
    #1;
  endtask

  task automatic drive(input logic st, input logic br, input logic [15:0] tgt, input logic [15:0] ins);
    PCStall = st; branch_taken = br; branch_target = tgt; imem_instr = ins;
  endtask

  // Compare process: every negedge, all outputs against the model.
  always @(negedge clock) begin
    if (cmp_on) begin
      chk("pc", 32'(pc), 32'(m_pc));
      chk("ifid_instr", 32'(ifid_instr), 32'(m_instr));
      chk("ifid_valid", 32'(ifid_valid), 32'(m_valid));
      chk("idex_bubble", 32'(idex_bubble), 32'(m_bubble()));
      chk("stall_timeout", 32'(stall_timeout), 32'(m_timeout));
      chk("stall_cycles", 32'(stall_cycles), 32'(m_perf()));
    end
  end

  initial begin
    int burst;
    int r;
    logic [15:0] held;
    reset = 1'b0;
    drive(1'b0, 1'b0, 16'h0000, 16'h2A81);
    model_reset();
    #12;
    chk("rst_pc", 32'(pc), 32'h0);
    chk("rst_valid", 32'(ifid_valid), 32'h0);
    chk("rst_instr", 32'(ifid_instr), 32'h0);
    chk("rst_bubble", 32'(idex_bubble), 32'h0);
    chk("rst_timeout", 32'(stall_timeout), 32'h0);
    cmp_on = 1'b1;
    @(posedge clock); #1;
    reset = 1'b1;

    // First fetch after reset release
    tick();
    chk("first_pc", 32'(pc), 32'h1);
    chk("first_instr", 32'(ifid_instr), 32'h2A81);
    chk("first_valid", 32'(ifid_valid), 32'h1);
    chk("first_bubble", 32'(idex_bubble), 32'h0);

    for (int i = 2; i <= 5; i++) begin
      drive(1'b0, 1'b0, 16'h0000, 16'(16'h1000 + i));
      tick();
    end
    chk("pre_stall_pc", 32'(pc), 32'h5);
    held = ifid_instr;

    // Three-edge stall at pc=5
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, 16'h0000, 16'hBEEF);
      #1 chk("stall_bubble", 32'(idex_bubble), 32'h1);
      tick();
      chk("stall_pc", 32'(pc), 32'h5);
      chk("stall_instr", 32'(ifid_instr), 32'(held));
    end
    drive(1'b0, 1'b0, 16'h0000, 16'h7777);
    #1 chk("release_bubble", 32'(idex_bubble), 32'h0);
    tick();
    chk("release_pc", 32'(pc), 32'h6);
    chk("release_instr", 32'(ifid_instr), 32'h7777);

    // Branch with simultaneous stall, then one FLUSH cycle
    drive(1'b1, 1'b1, 16'h0040, 16'h1111);
    #1 chk("br_bubble", 32'(idex_bubble), 32'h0);
    tick();
    chk("br_pc", 32'(pc), 32'h40);
    chk("br_instr", 32'(ifid_instr), 32'h0);
    chk("br_valid", 32'(ifid_valid), 32'h0);
    drive(1'b0, 1'b0, 16'h0000, 16'h2222);
    #1 chk("flush_bubble", 32'(idex_bubble), 32'h1);
    tick();
    chk("run_bubble", 32'(idex_bubble), 32'h0);
    chk("run_pc", 32'(pc), 32'h41);

    // Stall run reaching MAX_STALL
    for (int i = 1; i <= MAXS; i++) begin
      drive(1'b1, 1'b0, 16'h0000, 16'h3333);
      tick();
      if (i == MAXS - 1) chk("timeout_early", 32'(stall_timeout), 32'h0);
    end
    chk("timeout_set", 32'(stall_timeout), 32'h1);
    drive(1'b0, 1'b0, 16'h0000, 16'h4444);
    tick(); tick();
    chk("timeout_sticky", 32'(stall_timeout), 32'h1);

    // PC wrap
    drive(1'b0, 1'b1, 16'hFFFF, 16'h0000);
    tick();
    drive(1'b0, 1'b0, 16'h0000, 16'h5555);
    tick();
    chk("wrap_pc", 32'(pc), 32'h0);

    // Reset mid-stall
    drive(1'b1, 1'b0, 16'h0000, 16'h6666);
    tick();
    reset = 1'b0; model_reset();
    #1;
    chk("midrst_pc", 32'(pc), 32'h0);
    chk("midrst_valid", 32'(ifid_valid), 32'h0);
    chk("midrst_bubble", 32'(idex_bubble), 32'h0);
    chk("midrst_timeout", 32'(stall_timeout), 32'h0);
    @(posedge clock); #1;
    reset = 1'b1;

    // Performance counter: 5 stalls then stall+branch
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b0, 16'h0000, 16'h0000);
      tick();
    end
    drive(1'b1, 1'b1, 16'h0010, 16'h0000);
    tick();
`ifdef FETCH_STALL_PERF_EN
    chk("perf_count", 32'(stall_cycles), 32'd5);
`else
    chk("perf_count", 32'(stall_cycles), 32'd0);
`endif

    // Randomized phase
    burst = 0;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 199) == 0) begin
        reset = 1'b0; model_reset();
        drive(1'($urandom_range(0, 1)), 1'b0, 16'($urandom), 16'($urandom));
        tick();
        reset = 1'b1;
      end
      r = $urandom_range(0, 99);
      if (burst == 0 && r < 5) burst = $urandom_range(1, 12);
      if (burst > 0) begin
        burst--;
        drive(1'b1, ($urandom_range(0, 29) == 0), 16'($urandom), 16'($urandom));
      end else begin
        drive(r < 35, ($urandom_range(0, 9) == 0), 16'($urandom), 16'($urandom));
      end
      tick();
    end

    @(negedge clock);
    cmp_on = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
